flag_branch_ctrl: RTL

Sequencing controller for the flag register and the branch-resolution path of the pipelined CPU. It sits between decode (ID) and execute (EX). It issues the per-cycle `setFlag` and `CBZ_zero` controls to the flag register. It evaluates B.cond, CBZ and B in ID against the stored flags, stalls ID when a B.cond would read flags that are still being written, and squashes wrong-path instructions after a taken branch.

---
 rtl/flag_branch_ctrl_pkg.sv | 41 ++++
 rtl/flag_branch_ctrl_if.sv | 37 +++
 rtl/flag_branch_ctrl_cond_eval.sv | 34 +++
 rtl/flag_branch_ctrl_d_ff.sv | 17 +
 rtl/flag_branch_ctrl.sv | 112 +++++++++++
 5 files changed

// File: rtl/flag_branch_ctrl_pkg.sv
// Shared types for the flag/branch sequencing controller: instruction classes,
// ARM condition codes and the flush FSM state.
package flag_ctrl_pkg;

   typedef enum logic [2:0] {
      OP_NOP   = 3'd0,
      OP_ALU   = 3'd1,
      OP_ALUS  = 3'd2,
      OP_BCOND = 3'd3,
      OP_CBZ   = 3'd4,
      OP_B     = 3'd5
   } op_class_t;

   typedef enum logic {
      RUN   = 1'b0,
      FLUSH = 1'b1
   } state_t;

   localparam logic [3:0] COND_EQ = 4'h0;
   localparam logic [3:0] COND_NE = 4'h1;
   localparam logic [3:0] COND_HS = 4'h2;
   localparam logic [3:0] COND_LO = 4'h3;
   localparam logic [3:0] COND_MI = 4'h4;
   localparam logic [3:0] COND_PL = 4'h5;
   localparam logic [3:0] COND_VS = 4'h6;
   localparam logic [3:0] COND_VC = 4'h7;
   localparam logic [3:0] COND_HI = 4'h8;
   localparam logic [3:0] COND_LS = 4'h9;
   localparam logic [3:0] COND_GE = 4'hA;
   localparam logic [3:0] COND_LT = 4'hB;
   localparam logic [3:0] COND_GT = 4'hC;
   localparam logic [3:0] COND_LE = 4'hD;
   localparam logic [3:0] COND_AL = 4'hE;
   localparam logic [3:0] COND_NV = 4'hF;

   // Encodings 6 and 7 are unused and behave as NOP everywhere downstream.
   function automatic op_class_t decode_class(input logic [2:0] raw);
      return (raw > 3'd5) ? OP_NOP : op_class_t'(raw);
   endfunction

endpackage

// File: rtl/flag_branch_ctrl_if.sv
// ID-stage and flag-register signal bundle between the pipeline and the
// flag/branch controller.
interface flag_branch_ctrl_if #(parameter int CNT_W = 16);

   // id_valid qualifies the ID slot; stall is the hold-back: while stall=1 the
   // pipeline keeps the same instruction in ID and it is offered again next cycle.
   logic             id_valid;
   logic [2:0]       id_class;
   logic [3:0]       id_cond;
   logic             id_reg_zero;
   logic             flag_n;
   logic             flag_z;
   logic             flag_v;
   logic             flag_c;
   logic             set_flag;
   logic             cbz_zero;
   logic             stall;
   logic             flush;
   logic             branch_taken;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;

   modport master (
      output id_valid, id_class, id_cond, id_reg_zero,
      output flag_n, flag_z, flag_v, flag_c,
      input  set_flag, cbz_zero, stall, flush, branch_taken,
      input  stall_cnt, flush_cnt
   );

   modport slave (
      input  id_valid, id_class, id_cond, id_reg_zero,
      input  flag_n, flag_z, flag_v, flag_c,
      output set_flag, cbz_zero, stall, flush, branch_taken,
      output stall_cnt, flush_cnt
   );

endinterface

// File: rtl/flag_branch_ctrl_cond_eval.sv
// ARM condition-code evaluation against the stored N/Z/V/C flags.
module cond_eval
   import flag_ctrl_pkg::*;
(
   input  logic [3:0] cond,
   input  logic       n,
   input  logic       z,
   input  logic       v,
   input  logic       c,
   output logic       cond_true
);

   always_comb begin
      cond_true = 1'b1;
      case (cond)
         COND_EQ: cond_true = z;
         COND_NE: cond_true = !z;
         COND_HS: cond_true = c;
         COND_LO: cond_true = !c;
         COND_MI: cond_true = n;
         COND_PL: cond_true = !n;
         COND_VS: cond_true = v;
         COND_VC: cond_true = !v;
         COND_HI: cond_true = c & !z;
         COND_LS: cond_true = !c | z;
         COND_GE: cond_true = (n == v);
         COND_LT: cond_true = (n != v);
         COND_GT: cond_true = !z & (n == v);
         COND_LE: cond_true = z | (n != v);
         default: cond_true = 1'b1;
      endcase
   end

endmodule

// File: rtl/flag_branch_ctrl_d_ff.sv
// Plain D flip-flop bank with synchronous active-high clear; all controller
// state is held in instances of this cell, matching the flag register.
module d_ff #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   always_ff @(posedge clk) begin
      if (reset) q <= '0;
      else       q <= d;
   end

endmodule

// File: rtl/flag_branch_ctrl.sv
// Flag-register sequencing and ID-stage branch resolution: flag controls from
// the EX shadow, B.cond-after-ALUS hazard stall, and post-branch squash FSM.
module flag_branch_ctrl
   import flag_ctrl_pkg::*;
#(
   parameter int FLUSH_CYCLES = 1,
   parameter int CNT_W        = 16
) (
   input  logic               clk,
   input  logic               reset,
   flag_branch_ctrl_if.slave  bus
);

   localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);

   op_class_t        id_cls;
   op_class_t        ex_class;
   op_class_t        ex_class_nxt;
   logic [2:0]       ex_class_q;
   logic             ex_valid;
   logic             ex_valid_nxt;
   state_t           state;
   state_t           state_nxt;
   logic [0:0]       state_q;
   logic [2:0]       cnt;
   logic [2:0]       cnt_nxt;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] stall_cnt_nxt;
   logic [CNT_W-1:0] flush_cnt;
   logic [CNT_W-1:0] flush_cnt_nxt;
   logic             cond_true;
   logic             in_run;
   logic             stall;
   logic             flush;
   logic             branch_taken;

   d_ff #(.W(1))     u_state_ff (.clk(clk), .reset(reset), .d(state_nxt),     .q(state_q));
   d_ff #(.W(3))     u_cnt_ff   (.clk(clk), .reset(reset), .d(cnt_nxt),       .q(cnt));
   d_ff #(.W(1))     u_exv_ff   (.clk(clk), .reset(reset), .d(ex_valid_nxt),  .q(ex_valid));
   d_ff #(.W(3))     u_exc_ff   (.clk(clk), .reset(reset), .d(ex_class_nxt),  .q(ex_class_q));
   d_ff #(.W(CNT_W)) u_scnt_ff  (.clk(clk), .reset(reset), .d(stall_cnt_nxt), .q(stall_cnt));
   d_ff #(.W(CNT_W)) u_fcnt_ff  (.clk(clk), .reset(reset), .d(flush_cnt_nxt), .q(flush_cnt));

   assign state    = state_t'(state_q);
   assign ex_class = op_class_t'(ex_class_q);
   assign id_cls   = decode_class(bus.id_class);

   cond_eval u_cond_eval (
      .cond      (bus.id_cond),
      .n         (bus.flag_n),
      .z         (bus.flag_z),
      .v         (bus.flag_v),
      .c         (bus.flag_c),
      .cond_true (cond_true)
   );

   assign in_run = (state == RUN);
   assign flush  = (state == FLUSH);

   // The ALUS in EX writes flags on this edge, so a B.cond in ID must wait one
   // cycle; the bubble issued behind it removes the hazard by itself.
   assign stall = bus.id_valid & (id_cls == OP_BCOND) & ex_valid &
                  (ex_class == OP_ALUS) & in_run;

   assign branch_taken = bus.id_valid & in_run & !stall &
                         ((id_cls == OP_B) |
                          ((id_cls == OP_BCOND) & cond_true) |
                          ((id_cls == OP_CBZ) & bus.id_reg_zero));

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         RUN: begin
            if (branch_taken) begin
               state_nxt = FLUSH;
               cnt_nxt   = FLUSH_LOAD;
            end
         end
         FLUSH: begin
            cnt_nxt = cnt - 3'd1;
            if (cnt == 3'd1) state_nxt = RUN;
         end
         default: state_nxt = RUN;
      endcase
   end

   always_comb begin
      ex_valid_nxt = 1'b0;
      ex_class_nxt = ex_class;
      if (!stall && !flush) begin
         ex_valid_nxt = bus.id_valid;
         ex_class_nxt = id_cls;
      end
   end

   always_comb begin
      stall_cnt_nxt = stall_cnt;
      flush_cnt_nxt = flush_cnt;
      if (stall && (stall_cnt != '1)) stall_cnt_nxt = stall_cnt + CNT_W'(1);
      if (flush && (flush_cnt != '1)) flush_cnt_nxt = flush_cnt + CNT_W'(1);
   end

   assign bus.set_flag     = ex_valid & (ex_class == OP_ALUS);
   assign bus.cbz_zero     = ex_valid & (ex_class == OP_CBZ);
   assign bus.stall        = stall;
   assign bus.flush        = flush;
   assign bus.branch_taken = branch_taken;
   assign bus.stall_cnt    = stall_cnt;
   assign bus.flush_cnt    = flush_cnt;

endmodule
